pmem_line_responder: RTL

Synthesizable responder for the 256-bit cache-line physical-memory interface (`pmem_*`) that the CPU/cache top level drives as initiator. It accepts one line read or line write at a time and holds a local line array. It returns `pmem_resp` after a fixed, parameterized latency. It replaces the behavioral physical memory model in FPGA builds and checks initiator protocol compliance, reporting violations on a sticky error flag.

---
 rtl/pmem_line_responder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pmem_line_responder.sv
// Cache-line physical-memory responder: serves one 256-bit line read/write at a
// time after a fixed latency and flags initiator protocol violations stickily.
module pmem_line_responder #(
  parameter int INDEX_BITS = 8,
  parameter int LATENCY    = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [31:0]  pmem_address,
  input  logic [255:0] pmem_wdata,
  output logic         pmem_resp,
  output logic [255:0] pmem_rdata,
  output logic         proto_err
);

  localparam int IDX_HI = INDEX_BITS + 4;
  localparam int CNT_W  = 5;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY >= 2) ? LATENCY - 2 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    resp_q;
  logic [255:0]            rdata_q;
  logic                    err_q;

  logic                    wr_q;
  logic [31:0]             addr_q;
  logic [255:0]            wdata_q;

  logic [255:0]            mem_q [0:(1<<INDEX_BITS)-1];

  logic                    req_one;
  logic                    req_both;
  logic                    mismatch;
  logic                    in_idle;
  logic                    commit;
  logic                    op_wr;
  logic [INDEX_BITS-1:0]   idx;
  logic [255:0]            line_wdata;

  // With LATENCY==1 the op commits on the accepting edge, so it must use the
  // live request rather than the copy being latched on that same edge.
  always_comb begin
    req_one    = pmem_read ^ pmem_write;
    req_both   = pmem_read & pmem_write;
    in_idle    = (state_q == IDLE);
    mismatch   = (pmem_write != wr_q) || (pmem_read == wr_q) ||
                 (pmem_address != addr_q) || (pmem_wdata != wdata_q);
    commit     = in_idle ? (req_one && (LATENCY == 1))
                         : ((state_q == BUSY) && !mismatch && (cnt_q == '0));
    op_wr      = in_idle ? pmem_write : wr_q;
    idx        = in_idle ? pmem_address[IDX_HI:5] : addr_q[IDX_HI:5];
    line_wdata = in_idle ? pmem_wdata : wdata_q;
  end

  always_ff @(posedge clk) begin
    if (in_idle && req_one) begin
      wr_q    <= pmem_write;
      addr_q  <= pmem_address;
      wdata_q <= pmem_wdata;
    end
  end

  // Line array is deliberately not reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (commit && op_wr) begin
      mem_q[idx] <= line_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_both) begin
            err_q <= 1'b1;
          end else if (req_one) begin
            if (commit) begin
              state_q <= RESP;
              resp_q  <= 1'b1;
              if (!op_wr) rdata_q <= mem_q[idx];
            end else begin
              state_q <= BUSY;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        BUSY: begin
          // Abort wins over completion in the same cycle.
          if (mismatch) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else if (commit) begin
            state_q <= RESP;
            resp_q  <= 1'b1;
            if (!op_wr) rdata_q <= mem_q[idx];
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign pmem_resp  = resp_q;
  assign pmem_rdata = rdata_q;
  assign proto_err  = err_q;

endmodule
